// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// Holds the FSM state encoding, default pattern and the effective-length rule.
package seq_gen_pkg;

   localparam int SG_W  = 4;
   localparam int SG_LW = 3;
   localparam logic [SG_W-1:0] DEF_PAT = 4'b1001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      FIN  = 2'd3
   } state_e;

   // A length of zero, or one wider than the pattern, means "use the full width".
   function automatic int unsigned eff_len(input int unsigned len, input int unsigned w);
      if ((len == 32'd0) || (len > w)) begin
         return w;
      end else begin
         return len;
      end
   endfunction

endpackage

// File: rtl/seq_gen_ctr.sv
// Loadable down-counter with zero flag; load wins over decrement.
// Decrement never wraps below zero.
module seq_gen_ctr #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic             zero
);

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   // next count
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != {WIDTH{1'b0}})) begin
         cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {WIDTH{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter: sends a shadowed pattern MSB-first, repeated with zero gaps.
// Outputs are registered from the next-state view so the first bit appears one cycle after start.
module seq_gen_serial
   import seq_gen_pkg::*;
#(
   parameter int              W       = SG_W,
   parameter int              LW      = SG_LW,
   parameter logic [W-1:0]    DEF_PAT = seq_gen_pkg::DEF_PAT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          use_def,
   input  logic [W-1:0]  pattern,
   input  logic [LW-1:0] len,
   input  logic [7:0]    reps,
   input  logic [3:0]    gap,
   output logic          out,
   output logic          valid,
   output logic          busy,
   output logic          done
);

   localparam int BW = (W > 1) ? $clog2(W) : 1;

   state_e        state_q, state_d;
   logic [W-1:0]  pat_q, pat_d;
   logic [LW-1:0] len_q, len_d;
   logic [3:0]    gap_q, gap_d;
   logic          out_q, out_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [W-1:0]  pat_sel_s;
   logic [LW-1:0] len_eff_s;

   logic          bit_load_s, bit_dec_s, bit_zero_s;
   logic [BW-1:0] bit_val_s, bit_idx_s;
   logic          gap_load_s, gap_dec_s, gap_zero_s;
   logic [3:0]    gap_val_s, gap_cnt_s;
   logic          rep_load_s, rep_dec_s, rep_zero_s;
   logic [7:0]    rep_val_s, rep_cnt_s;

   assign pat_sel_s = use_def ? DEF_PAT : pattern;
   assign len_eff_s = LW'(eff_len({{(32-LW){1'b0}}, len}, unsigned'(W)));

   seq_gen_ctr #(.WIDTH(BW)) u_bit_ctr (
      .clk(clk), .rst(rst), .load(bit_load_s), .dec(bit_dec_s),
      .load_val(bit_val_s), .cnt(bit_idx_s), .zero(bit_zero_s)
   );

   seq_gen_ctr #(.WIDTH(4)) u_gap_ctr (
      .clk(clk), .rst(rst), .load(gap_load_s), .dec(gap_dec_s),
      .load_val(gap_val_s), .cnt(gap_cnt_s), .zero(gap_zero_s)
   );

   seq_gen_ctr #(.WIDTH(8)) u_rep_ctr (
      .clk(clk), .rst(rst), .load(rep_load_s), .dec(rep_dec_s),
      .load_val(rep_val_s), .cnt(rep_cnt_s), .zero(rep_zero_s)
   );

   // next state, shadow loads, counter control and next output values
   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      len_d      = len_q;
      gap_d      = gap_q;
      out_d      = 1'b0;
      valid_d    = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      bit_load_s = 1'b0;
      bit_dec_s  = 1'b0;
      bit_val_s  = BW'(len_q - LW'(1));
      gap_load_s = 1'b0;
      gap_dec_s  = 1'b0;
      gap_val_s  = gap_q;
      rep_load_s = 1'b0;
      rep_dec_s  = 1'b0;
      rep_val_s  = reps;

      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  pat_d      = pat_sel_s;
                  len_d      = len_eff_s;
                  gap_d      = gap;
                  rep_load_s = 1'b1;
                  if (reps != 8'd0) begin
                     state_d    = SEND;
                     bit_load_s = 1'b1;
                     bit_val_s  = BW'(len_eff_s - LW'(1));
                     out_d      = pat_sel_s[BW'(len_eff_s - LW'(1))];
                     valid_d    = 1'b1;
                     busy_d     = 1'b1;
                  end else begin
                     state_d = FIN;
                     done_d  = 1'b1;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            SEND: begin
               if (!bit_zero_s) begin
                  bit_dec_s = 1'b1;
                  out_d     = pat_q[bit_idx_s - BW'(1)];
                  valid_d   = 1'b1;
                  busy_d    = 1'b1;
               end else begin
                  rep_dec_s = 1'b1;
                  // rep_zero_s only guards against a corrupted counter
                  if ((rep_cnt_s == 8'd1) || rep_zero_s) begin
                     state_d = FIN;
                     done_d  = 1'b1;
                  end else if (gap_q != 4'd0) begin
                     state_d    = GAP;
                     gap_load_s = 1'b1;
                     busy_d     = 1'b1;
                  end else begin
                     bit_load_s = 1'b1;
                     out_d      = pat_q[BW'(len_q - LW'(1))];
                     valid_d    = 1'b1;
                     busy_d     = 1'b1;
                  end
               end
            end
            GAP: begin
               busy_d = 1'b1;
               if ((gap_cnt_s == 4'd1) || gap_zero_s) begin
                  state_d    = SEND;
                  bit_load_s = 1'b1;
                  out_d      = pat_q[BW'(len_q - LW'(1))];
                  valid_d    = 1'b1;
               end else begin
                  gap_dec_s = 1'b1;
               end
            end
            FIN: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // state, shadow and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pat_q   <= {W{1'b0}};
         len_q   <= {LW{1'b0}};
         gap_q   <= 4'd0;
         out_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         gap_q   <= gap_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_seq_gen_serial.sv
// Directed bench for seq_gen_serial: captures the serial stream cycle by cycle
// and compares it against hand-computed bit strings.
module tb_seq_gen_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic       use_def;
   logic [3:0] pattern;
   logic [2:0] len;
   logic [7:0] reps;
   logic [3:0] gap;
   logic       out_s, valid_s, busy_s, done_s;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] o_v, v_v, b_v, d_v;
   logic [3:0]  sh;
   int          z_cnt;

   seq_gen_serial dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .use_def(use_def),
      .pattern(pattern), .len(len), .reps(reps), .gap(gap),
      .out(out_s), .valid(valid_s), .busy(busy_s), .done(done_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after edge k
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // samples n cycles starting with the current one, first sample ends up as MSB
   task automatic collect(input int n, output logic [31:0] o, output logic [31:0] v,
                          output logic [31:0] b, output logic [31:0] d);
      o = 32'd0; v = 32'd0; b = 32'd0; d = 32'd0;
      for (int i = 0; i < n; i++) begin
         o = {o[30:0], out_s};
         v = {v[30:0], valid_s};
         b = {b[30:0], busy_s};
         d = {d[30:0], done_s};
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; use_def = 1'b0;
      pattern = 4'b0000; len = 3'd4; reps = 8'd0; gap = 4'd0;
      repeat (2) @(negedge clk);
      chk("rst_out",   {31'd0, out_s},   32'd0);
      chk("rst_valid", {31'd0, valid_s}, 32'd0);
      chk("rst_busy",  {31'd0, busy_s},  32'd0);
      chk("rst_done",  {31'd0, done_s},  32'd0);
      rst = 1'b0;
      @(negedge clk);

      // default pattern, three back-to-back repetitions
      use_def = 1'b1; pattern = 4'b0000; len = 3'd4; reps = 8'd3; gap = 4'd0;
      pulse_start();
      collect(14, o_v, v_v, b_v, d_v);
      chk("t1_out",   o_v, 32'(14'b10011001100100));
      chk("t1_valid", v_v, 32'(14'b11111111111100));
      chk("t1_busy",  b_v, 32'(14'b11111111111100));
      chk("t1_done",  d_v, 32'(14'b00000000000010));
      sh = 4'd0; z_cnt = 0;
      for (int i = 13; i >= 2; i--) begin
         sh = {sh[2:0], o_v[i]};
         if (sh == 4'b1001) z_cnt++;
      end
      chk("t1_detect", 32'(z_cnt), 32'd3);

      // explicit pattern with a two-cycle gap
      use_def = 1'b0; pattern = 4'b1011; len = 3'd4; reps = 8'd2; gap = 4'd2;
      pulse_start();
      collect(12, o_v, v_v, b_v, d_v);
      chk("t2_out",   o_v, 32'(12'b101100101100));
      chk("t2_valid", v_v, 32'(12'b111100111100));
      chk("t2_busy",  b_v, 32'(12'b111111111100));
      chk("t2_done",  d_v, 32'(12'b000000000010));

      // zero repetitions
      reps = 8'd0; gap = 4'd0;
      pulse_start();
      collect(3, o_v, v_v, b_v, d_v);
      chk("t3_valid", v_v, 32'd0);
      chk("t3_busy",  b_v, 32'd0);
      chk("t3_done",  d_v, 32'(3'b100));

      // len=0 means full width
      pattern = 4'b0110; len = 3'd0; reps = 8'd1;
      pulse_start();
      collect(6, o_v, v_v, b_v, d_v);
      chk("t4a_out",   o_v, 32'(6'b011000));
      chk("t4a_valid", v_v, 32'(6'b111100));
      chk("t4a_done",  d_v, 32'(6'b000010));
      len = 3'd2;
      pulse_start();
      collect(4, o_v, v_v, b_v, d_v);
      chk("t4b_out",   o_v, 32'(4'b1000));
      chk("t4b_valid", v_v, 32'(4'b1100));
      chk("t4b_done",  d_v, 32'(4'b0010));

      // start while busy is ignored, abort drops the transfer
      pattern = 4'b1011; len = 3'd4; reps = 8'd2; gap = 4'd0;
      pulse_start();
      chk("t5_c1_out", {31'd0, out_s}, 32'd1);
      @(negedge clk);
      chk("t5_c2_out", {31'd0, out_s}, 32'd0);
      start = 1'b1; pattern = 4'b0000; len = 3'd2;
      @(negedge clk);
      start = 1'b0;
      chk("t5_c3_out",  {31'd0, out_s},  32'd1);
      chk("t5_c3_busy", {31'd0, busy_s}, 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5_ab_out",   {31'd0, out_s},   32'd0);
      chk("t5_ab_valid", {31'd0, valid_s}, 32'd0);
      chk("t5_ab_busy",  {31'd0, busy_s},  32'd0);
      collect(3, o_v, v_v, b_v, d_v);
      chk("t5_post_busy", b_v, 32'd0);
      chk("t5_post_done", d_v | {31'd0, done_s}, 32'd0);

      // abort and start together in IDLE
      pattern = 4'b1011; len = 3'd4; reps = 8'd1;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      collect(2, o_v, v_v, b_v, d_v);
      chk("t5b_valid", v_v, 32'd0);
      chk("t5b_busy",  b_v, 32'd0);
      chk("t5b_done",  d_v, 32'd0);

      // asynchronous reset mid-SEND, then a fresh transfer
      pulse_start();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_out",   {31'd0, out_s},   32'd0);
      chk("t6_rst_valid", {31'd0, valid_s}, 32'd0);
      chk("t6_rst_busy",  {31'd0, busy_s},  32'd0);
      @(negedge clk);
      rst = 1'b0;
      collect(3, o_v, v_v, b_v, d_v);
      chk("t6_no_done", d_v, 32'd0);
      pulse_start();
      collect(6, o_v, v_v, b_v, d_v);
      chk("t6_out",   o_v, 32'(6'b101100));
      chk("t6_valid", v_v, 32'(6'b111100));
      chk("t6_done",  d_v, 32'(6'b000010));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
